// File: rtl/xpr_pkg.sv
// xpr_pkg: shared FSM state type, raw-bit type and default constants for the XPR entropy sampler.
package xpr_pkg;

  localparam int XPR_WORD_W_DEF        = 32;
  localparam int XPR_RESET_CYCLES_DEF  = 4;
  localparam int XPR_SETTLE_CYCLES_DEF = 16;
  localparam int XPR_STUCK_LIMIT_DEF   = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FAIL   = 3'd4
  } xpr_state_e;

  typedef logic raw_bit_t;

  // Width of a counter that must hold every value in 0..max_val.
  function automatic int xpr_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xpr_sync2.sv
// xpr_sync2: two-flop synchronizer bringing one asynchronous slice output into the clock domain.
module xpr_sync2
  import xpr_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     async_in,
  output raw_bit_t sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/xpr_sampler.sv
// xpr_sampler: XPR slice-pair round controller, raw-bit health check, packer and valid/ready source.
// Optional build macro XPR_SAMPLER_VN_EN enables von Neumann conditioning of raw-bit pairs.
module xpr_sampler
  import xpr_pkg::*;
#(
  parameter int WORD_W        = XPR_WORD_W_DEF,
  parameter int RESET_CYCLES  = XPR_RESET_CYCLES_DEF,
  parameter int SETTLE_CYCLES = XPR_SETTLE_CYCLES_DEF,
  parameter int STUCK_LIMIT   = XPR_STUCK_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        cfg_challenge,
  output logic              slice_iR,
  output logic              slice_i1,
  output logic              slice_i2,
  input  logic              slice_out1,
  input  logic              slice_out2,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [WORD_W-1:0] rnd_data,
  output logic              health_fail
);

  localparam int PH_MAX = ((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES) - 1;
  localparam int PH_W   = xpr_cnt_w(PH_MAX);
  localparam int BC_W   = xpr_cnt_w(WORD_W - 1);
  localparam int HC_W   = xpr_cnt_w(STUCK_LIMIT);

  localparam logic [PH_W-1:0] RST_LAST  = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0] RUN_LAST  = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
  localparam logic [HC_W-1:0] STUCK_VAL = HC_W'(STUCK_LIMIT);

  // Synchronized slice outputs
  logic [1:0] slice_async;
  raw_bit_t   slice_sync [2];
  raw_bit_t   raw_bit;

  assign slice_async = {slice_out2, slice_out1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      xpr_sync2 u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (slice_async[gi]),
        .sync_out (slice_sync[gi])
      );
    end
  endgenerate

  assign raw_bit = slice_sync[0] ^ slice_sync[1];

  // Round controller state
  xpr_state_e      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [1:0]      chal_q, chal_d;
  logic            slice_ir_q, slice_ir_d;

  // Harvest datapath state
  logic [HC_W-1:0]   health_cnt_q, health_cnt_d;
  raw_bit_t          last_raw_q, last_raw_d;
  logic              health_fail_q, health_fail_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rnd_data_q, rnd_data_d;
  logic              rnd_valid_q, rnd_valid_d;
`ifdef XPR_SAMPLER_VN_EN
  logic              pair_have_q, pair_have_d;
  raw_bit_t          pair_bit_q, pair_bit_d;
`endif

  logic              do_sample;
  logic              trip;
  logic              acc_valid;
  raw_bit_t          acc_bit;
  logic [WORD_W-1:0] packed_word;

  assign do_sample = (state_q == ST_SAMPLE);

  // Health check, conditioning, packing and the output handshake
  always_comb begin
    health_cnt_d  = health_cnt_q;
    last_raw_d    = last_raw_q;
    health_fail_d = health_fail_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    rnd_data_d    = rnd_data_q;
    rnd_valid_d   = rnd_valid_q;
`ifdef XPR_SAMPLER_VN_EN
    pair_have_d   = pair_have_q;
    pair_bit_d    = pair_bit_q;
`endif
    trip          = 1'b0;
    acc_valid     = 1'b0;
    acc_bit       = 1'b0;
    packed_word   = {acc_bit, shift_q};

    if (rnd_valid_q && rnd_ready) begin
      rnd_valid_d = 1'b0;
    end

    if (do_sample) begin
      last_raw_d = raw_bit;
      if ((health_cnt_q == '0) || (raw_bit != last_raw_q)) begin
        health_cnt_d = HC_W'(1);
      end else begin
        health_cnt_d = health_cnt_q + HC_W'(1);
      end

      if (health_cnt_d == STUCK_VAL) begin
        // A stuck source poisons the word in progress; a word already presented is kept.
        trip          = 1'b1;
        health_fail_d = 1'b1;
        shift_d       = '0;
        bit_cnt_d     = '0;
`ifdef XPR_SAMPLER_VN_EN
        pair_have_d   = 1'b0;
        pair_bit_d    = 1'b0;
`endif
      end else begin
`ifdef XPR_SAMPLER_VN_EN
        if (!pair_have_q) begin
          pair_have_d = 1'b1;
          pair_bit_d  = raw_bit;
        end else begin
          pair_have_d = 1'b0;
          if (pair_bit_q != raw_bit) begin
            acc_valid = 1'b1;
            acc_bit   = pair_bit_q;
          end
        end
`else
        acc_valid = 1'b1;
        acc_bit   = raw_bit;
`endif
        if (acc_valid) begin
          // New bits enter at the MSB so the first bit lands in bit 0 of the word.
          packed_word = {acc_bit, shift_q};
          shift_d     = packed_word[WORD_W-1:1];
          if (bit_cnt_q == BIT_LAST) begin
            rnd_data_d  = packed_word;
            rnd_valid_d = 1'b1;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !rnd_valid_q && !health_fail_q) begin
          state_d = ST_RST;
          phase_d = '0;
        end
      end
      ST_RST: begin
        if (phase_q == RST_LAST) begin
          phase_d = '0;
          state_d = enable ? ST_RUN : ST_IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        if (phase_q == RUN_LAST) begin
          phase_d = '0;
          state_d = enable ? ST_SAMPLE : ST_IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_SAMPLE: begin
        phase_d = '0;
        if (trip) begin
          state_d = ST_FAIL;
        end else if (enable && !rnd_valid_d) begin
          state_d = ST_RST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Output logic: slice controls are registered from the next state to stay glitch-free
  always_comb begin
    slice_ir_d = (state_d == ST_RUN) || (state_d == ST_SAMPLE);
    chal_d     = chal_q;
    if ((state_d == ST_RST) && (state_q != ST_RST)) begin
      chal_d = cfg_challenge;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      chal_q     <= 2'b00;
      slice_ir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      chal_q     <= chal_d;
      slice_ir_q <= slice_ir_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      health_cnt_q  <= '0;
      last_raw_q    <= 1'b0;
      health_fail_q <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
`ifdef XPR_SAMPLER_VN_EN
      pair_have_q   <= 1'b0;
      pair_bit_q    <= 1'b0;
`endif
    end else begin
      health_cnt_q  <= health_cnt_d;
      last_raw_q    <= last_raw_d;
      health_fail_q <= health_fail_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
`ifdef XPR_SAMPLER_VN_EN
      pair_have_q   <= pair_have_d;
      pair_bit_q    <= pair_bit_d;
`endif
    end
  end

  assign slice_iR    = slice_ir_q;
  assign slice_i1    = chal_q[0];
  assign slice_i2    = chal_q[1];
  assign rnd_valid   = rnd_valid_q;
  assign rnd_data    = rnd_data_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_xpr_sampler.sv
// tb_xpr_sampler: randomized self-checking bench for xpr_sampler against a round-level reference model.
module tb_xpr_sampler;

  localparam int W     = 32;
  localparam int RC    = 4;
  localparam int SC    = 16;
  localparam int SL    = 64;
  localparam int ROUND = RC + SC + 1;
`ifdef XPR_SAMPLER_VN_EN
  localparam int ALT_N = 64;
`else
  localparam int ALT_N = 32;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   cfg_challenge = 2'b00;
  logic         slice_iR, slice_i1, slice_i2;
  logic         slice_out1 = 1'b0;
  logic         slice_out2 = 1'b0;
  logic         rnd_valid;
  logic         rnd_ready = 1'b0;
  logic [W-1:0] rnd_data;
  logic         health_fail;

  int vectors = 0;
  int miscompares = 0;

  bit           raw_bits [0:1023];
  int           round_idx = 0;
  bit           drv_b;
  logic [W-1:0] exp_words [$];
  int           exp_word_round [$];
  int           trip_round;
  logic [W-1:0] got_words [$];

  always #5 clock = ~clock;

  xpr_sampler #(
    .WORD_W        (W),
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .STUCK_LIMIT   (SL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .cfg_challenge (cfg_challenge),
    .slice_iR      (slice_iR),
    .slice_i1      (slice_i1),
    .slice_i2      (slice_i2),
    .slice_out1    (slice_out1),
    .slice_out2    (slice_out2),
    .rnd_valid     (rnd_valid),
    .rnd_ready     (rnd_ready),
    .rnd_data      (rnd_data),
    .health_fail   (health_fail)
  );

  // Slice emulator: each release starts a round whose raw XOR is raw_bits[round], with a random split.
  always @(posedge slice_iR or posedge reset) begin
    if (reset) begin
      round_idx = 0;
    end else begin
      drv_b      = 1'($urandom_range(0, 1));
      slice_out2 = drv_b;
      slice_out1 = raw_bits[round_idx % 1024] ^ drv_b;
      round_idx  = round_idx + 1;
    end
  end

  // Transfer monitor: valid & ready seen mid-cycle means the word moves on the next edge.
  always @(negedge clock) begin
    if (!reset && rnd_valid && rnd_ready) begin
      got_words.push_back(rnd_data);
      $display("word %0d accepted: %h", got_words.size() - 1, rnd_data);
    end
  end

  // Reference: walk the raw bits round by round, apply health rule, optional pairing, pack words.
  task automatic model_run(input int nrounds);
    int           run;
    bit           prev, r, first, have;
    bit           acc [$];
    logic [W-1:0] w;
    exp_words.delete();
    exp_word_round.delete();
    trip_round = -1;
    run = 0; prev = 1'b0; have = 1'b0; first = 1'b0;
    for (int n = 0; n < nrounds; n++) begin
      r = raw_bits[n];
      run = (n > 0 && r == prev) ? run + 1 : 1;
      prev = r;
      if (run >= SL) begin
        trip_round = n;
        break;
      end
`ifdef XPR_SAMPLER_VN_EN
      if (!have) begin
        first = r; have = 1'b1;
      end else begin
        have = 1'b0;
        if (first != r) acc.push_back(first);
      end
`else
      acc.push_back(r);
`endif
      if (acc.size() == W) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = acc[i];
        exp_words.push_back(w);
        exp_word_round.push_back(n);
        acc.delete();
      end
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_word(output int cyc, input int limit);
    cyc = 0;
    while (!rnd_valid && cyc < limit) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (rnd_data !== '0 || {slice_i2, slice_i1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_values: rnd_data=%h chal=%b, expected 0 and 00", rnd_data, {slice_i2, slice_i1});
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      vectors++;
      if ({slice_iR, rnd_valid, health_fail} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: iR/valid/hf=%b, expected 000", c, {slice_iR, rnd_valid, health_fail});
      end
    end
  endtask

  task automatic test_challenge();
    logic [1:0] c1, c2;
    int cyc;
    do_reset();
    c1 = 2'($urandom_range(0, 3));
    c2 = c1 ^ 2'($urandom_range(1, 3));
    cfg_challenge = c1;
    enable = 1'b1;
    cyc = 0;
    while (!slice_iR && cyc < 40) begin @(posedge clock); #1; cyc++; end
    vectors++;
    if ({slice_i2, slice_i1} !== c1 || !slice_iR) begin
      miscompares++;
      $display("FAIL challenge_first: chal=%b iR=%b, expected %b and 1", {slice_i2, slice_i1}, slice_iR, c1);
    end
    cfg_challenge = c2;
    repeat (5) @(posedge clock);
    #1;
    vectors++;
    if ({slice_i2, slice_i1} !== c1) begin
      miscompares++;
      $display("FAIL challenge_hold: chal=%b, expected %b", {slice_i2, slice_i1}, c1);
    end
    cyc = 0;
    while (slice_iR && cyc < 40) begin @(posedge clock); #1; cyc++; end
    vectors++;
    if ({slice_i2, slice_i1} !== c2) begin
      miscompares++;
      $display("FAIL challenge_next_round: chal=%b, expected %b", {slice_i2, slice_i1}, c2);
    end
    enable = 1'b0;
    repeat (30) @(posedge clock);
    #1;
  endtask

  task automatic test_first_word();
    int cyc, exp_lat;
    logic [W-1:0] alt_word;
    do_reset();
    for (int n = 0; n < 1024; n++)
      raw_bits[n] = (n < ALT_N) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
    model_run(1024);
    exp_lat = (exp_word_round[0] + 1) * ROUND;
    enable = 1'b1;
    @(posedge clock); #1;
    wait_word(cyc, 5000);
    vectors++;
    if (cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL first_word_latency: got %0d cycles, expected %0d", cyc, exp_lat);
    end
    vectors++;
    if (rnd_data !== exp_words[0]) begin
      miscompares++;
      $display("FAIL first_word_data: got %h, expected %h", rnd_data, exp_words[0]);
    end
`ifndef XPR_SAMPLER_VN_EN
    alt_word = 32'h5555_5555;
    vectors++;
    if (rnd_data !== alt_word) begin
      miscompares++;
      $display("FAIL alt_word_value: got %h, expected %h", rnd_data, alt_word);
    end
`else
    alt_word = '0;
`endif
  endtask

  task automatic test_backpressure();
    int cyc, base;
    base = got_words.size();
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      vectors++;
      if (rnd_valid !== 1'b1 || rnd_data !== exp_words[0] || slice_iR !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: valid=%b data=%h iR=%b, expected 1 %h 0", c, rnd_valid, rnd_data, slice_iR, exp_words[0]);
      end
    end
    rnd_ready = 1'b1;
    @(posedge clock); #1;
    rnd_ready = 1'b0;
    vectors++;
    if (rnd_valid !== 1'b0 || got_words.size() != base + 1) begin
      miscompares++;
      $display("FAIL accept_drop: valid=%b transfers=%0d, expected 0 and 1", rnd_valid, got_words.size() - base);
    end
    cyc = 0;
    while (!slice_iR && cyc < 40) begin @(posedge clock); #1; cyc++; end
    vectors++;
    if (cyc !== 1 + RC) begin
      miscompares++;
      $display("FAIL restart_delay: release after %0d cycles, expected %0d", cyc, 1 + RC);
    end
    wait_word(cyc, 30000);
    vectors++;
    if (rnd_valid !== 1'b1 || rnd_data !== exp_words[1]) begin
      miscompares++;
      $display("FAIL second_word: valid=%b data=%h, expected 1 %h", rnd_valid, rnd_data, exp_words[1]);
    end
    enable = 1'b0;
  endtask

`ifdef XPR_SAMPLER_VN_EN
  task automatic test_vn();
    int cyc, exp_lat;
    bit pat [8];
    logic [W-1:0] vn_word;
    pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int n = 0; n < 1024; n++) raw_bits[n] = pat[n % 8];
    model_run(1024);
    exp_lat = (exp_word_round[0] + 1) * ROUND;
    vn_word = 32'hAAAA_AAAA;
    enable = 1'b1;
    @(posedge clock); #1;
    wait_word(cyc, 5000);
    vectors++;
    if (cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL vn_latency: got %0d cycles, expected %0d", cyc, exp_lat);
    end
    vectors++;
    if (rnd_data !== vn_word || rnd_data !== exp_words[0]) begin
      miscompares++;
      $display("FAIL vn_word: got %h, expected %h", rnd_data, vn_word);
    end
    enable = 1'b0;
  endtask
`endif

  task automatic test_random_words();
    int cyc, base;
    logic pv, pr;
    logic [W-1:0] pd;
    do_reset();
    for (int n = 0; n < 1024; n++) raw_bits[n] = 1'($urandom_range(0, 1));
    model_run(1024);
    base = got_words.size();
    enable = 1'b1;
    cyc = 0;
    while ((got_words.size() - base) < 3 && cyc < 40000) begin
      rnd_ready = 1'($urandom_range(0, 1));
      pv = rnd_valid; pr = rnd_ready; pd = rnd_data;
      @(posedge clock); #1;
      cyc++;
      if (pv && !pr) begin
        vectors++;
        if (rnd_valid !== 1'b1 || rnd_data !== pd) begin
          miscompares++;
          $display("FAIL random_stall: valid=%b data=%h, expected 1 %h", rnd_valid, rnd_data, pd);
        end
      end
    end
    rnd_ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ((got_words.size() - base) <= i || got_words[base + i] !== exp_words[i]) begin
        miscompares++;
        $display("FAIL random_word %0d: got %h (transfers %0d), expected %h", i,
                 ((got_words.size() - base) > i) ? got_words[base + i] : '0, got_words.size() - base, exp_words[i]);
      end
    end
  endtask

  task automatic test_health();
    int cyc, base, rounds_at_trip;
    logic prev_ir;
    do_reset();
    for (int n = 0; n < 1024; n++) raw_bits[n] = 1'b1;
    model_run(1024);
    base = got_words.size();
    rnd_ready = 1'b1;
    enable = 1'b1;
    cyc = 0;
    prev_ir = 1'b0;
    while (!health_fail && cyc < 3000) begin
      prev_ir = slice_iR;
      @(posedge clock); #1;
      cyc++;
    end
    rounds_at_trip = round_idx;
    vectors++;
    if (health_fail !== 1'b1 || rounds_at_trip != trip_round + 1) begin
      miscompares++;
      $display("FAIL health_trip: hf=%b after %0d rounds, expected 1 after %0d", health_fail, rounds_at_trip, trip_round + 1);
    end
    vectors++;
    if (prev_ir !== 1'b1 || slice_iR !== 1'b0) begin
      miscompares++;
      $display("FAIL health_trip_edge: iR before/after=%b%b, expected 10", prev_ir, slice_iR);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      vectors++;
      if ({slice_iR, rnd_valid, health_fail} !== 3'b001 || round_idx != rounds_at_trip) begin
        miscompares++;
        $display("FAIL fail_state cycle %0d: iR/valid/hf=%b rounds=%0d, expected 001 %0d", c, {slice_iR, rnd_valid, health_fail}, round_idx, rounds_at_trip);
      end
    end
    vectors++;
    if ((got_words.size() - base) != exp_words.size()) begin
      miscompares++;
      $display("FAIL health_words: got %0d words, expected %0d", got_words.size() - base, exp_words.size());
    end else begin
      for (int i = 0; i < exp_words.size(); i++) begin
        vectors++;
        if (got_words[base + i] !== exp_words[i]) begin
          miscompares++;
          $display("FAIL health_word %0d: got %h, expected %h", i, got_words[base + i], exp_words[i]);
        end
      end
    end
    rnd_ready = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int cyc, exp_lat;
    do_reset();
    for (int n = 0; n < 1024; n++)
      raw_bits[n] = (n < ALT_N) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
    model_run(1024);
    exp_lat = (exp_word_round[0] + 1) * ROUND;
    enable = 1'b1;
    cyc = 0;
    while (!(round_idx == 5 && slice_iR) && cyc < 500) begin @(posedge clock); #1; cyc++; end
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (slice_iR !== 1'b0 || rnd_valid !== 1'b0 || round_idx != 0) begin
      miscompares++;
      $display("FAIL async_reset: iR=%b valid=%b, expected 0 0", slice_iR, rnd_valid);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    wait_word(cyc, 5000);
    vectors++;
    if (cyc !== exp_lat || rnd_data !== exp_words[0]) begin
      miscompares++;
      $display("FAIL post_reset_word: %0d cycles data %h, expected %0d cycles data %h", cyc, rnd_data, exp_lat, exp_words[0]);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_challenge();
    test_first_word();
    test_backpressure();
`ifdef XPR_SAMPLER_VN_EN
    test_vn();
`endif
    test_random_words();
    test_health();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xpr_sampler.md
# xpr_sampler

Controller and harvester for one XPR entropy slice pair. Drives the slice release line and challenge bits, runs a fixed reset/oscillate/sample cycle, conditions the raw bits, packs them into words and hands each word to the SoC over a valid/ready stream. Sits between the XPR slice array and the TRNG register block.

## Interface
- `WORD_W`, 32: output word width, ≥ 2.
- `RESET_CYCLES`, 4: cycles `slice_iR` is held 0 per round, ≥ 1.
- `SETTLE_CYCLES`, 16: cycles `slice_iR` is held 1 per round, ≥ 3.
- `STUCK_LIMIT`, 64: identical consecutive raw samples that trip the health check, ≥ 2.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run sampling rounds.
- `cfg_challenge` in 2: drives `{slice_i2, slice_i1}`, sampled at round start.
- `slice_iR` out 1: slice release; 0 forces the slice AND nodes low.
- `slice_i1`, `slice_i2` out 1 each: challenge bits.
- `slice_out1`, `slice_out2` in 1 each: asynchronous slice outputs.
- `rnd_valid` out 1: `rnd_data` holds a full word.
- `rnd_ready` in 1: consumer accepts the word.
- `rnd_data` out `WORD_W`: packed random word.
- `health_fail` out 1: sticky stuck-source flag.

## Operation
- Reset values: `slice_iR`=0, `slice_i1`/`slice_i2`=0, `rnd_valid`=0, `rnd_data`=0, `health_fail`=0; state IDLE, bit count 0.
- Each of `slice_out1`/`slice_out2` passes through a 2-flop synchronizer.
- FSM states: IDLE, RST, RUN, SAMPLE, FAIL.
  - IDLE: `slice_iR`=0. Goes to RST when `enable`=1, `rnd_valid`=0 and `health_fail`=0. On that transition the challenge register latches `cfg_challenge`.
  - RST: `slice_iR`=0 for `RESET_CYCLES` cycles, then RUN.
  - RUN: `slice_iR`=1 for `SETTLE_CYCLES` cycles, then SAMPLE.
  - SAMPLE: one cycle, `slice_iR`=1. Raw bit = synchronized `out1` XOR `out2`.
    - Raw bit goes to the conditioner and the health counter.
    - Next state: FAIL if the health check just tripped. Otherwise RST if `enable`=1 and no word is pending. Otherwise IDLE.
  - FAIL: `slice_iR`=0, no further rounds. Left only by `reset`.
- Health check:
  - Counter of consecutive identical raw bits; it resets to 1 on any change.
  - Reaching `STUCK_LIMIT` sets `health_fail`.
  - The partially packed word is discarded. A word already presented stays valid until accepted.
- Packing:
  - Accepted bits shift in MSB-first: first bit ends at bit 0 after `WORD_W` shifts.
  - When the count reaches `WORD_W`, `rnd_data` is loaded, `rnd_valid` is set and the count clears.
- Handshake:
  - Transfer occurs on a cycle with `rnd_valid` & `rnd_ready`. `rnd_valid` drops the next cycle.
  - `rnd_data` is held stable while `rnd_valid`=1.
  - `rnd_ready` is ignored while `rnd_valid`=0.
- `enable` deasserted mid-round: the round finishes its current state, then goes to IDLE at the next state boundary; no raw bit is taken if SAMPLE is not reached. Partial word and counters are retained.
- A `cfg_challenge` change mid-round takes effect at the next round start.

## Timing
- Round length = `RESET_CYCLES` + `SETTLE_CYCLES` + 1 cycles (21 at defaults).
- The sampled value reflects slice outputs 2 cycles before SAMPLE.
- Without conditioning, the first word is valid `WORD_W` rounds after leaving IDLE (672 cycles at defaults). `rnd_valid` rises the cycle after the final SAMPLE.
- Backpressure stalls sampling: no round starts while a word is pending. Throughput is therefore ≤ 1 word per `WORD_W` rounds.
- `reset` mid-round forces `slice_iR`=0 and `rnd_valid`=0 asynchronously. The partial word is lost.

## Configuration
- `XPR_SAMPLER_VN_EN` defined: von Neumann conditioning on consecutive raw-bit pairs. Pair 01 yields accepted bit 0, pair 10 yields 1; 00 and 11 are discarded. The pair register clears on reset and on a health trip.
- Not defined: every raw bit is accepted directly.
- The health check always operates on raw bits.

## Structure
- Package `xpr_pkg`: FSM state enum, default parameter constants, raw-bit type.
- Sub-module `xpr_sync2`: 2-flop synchronizer, instantiated once per slice output.

## Test plan
- Reset, `enable`=0 for 200 cycles → `slice_iR`=0, `rnd_valid`=0, `health_fail`=0 throughout.
- No VN, defaults, bench forces raw sequence 1,0,1,0… → `rnd_data`=32'h5555_5555, `rnd_valid` rises 672 cycles after `enable`.
- Word pending, `rnd_ready`=0 for 100 cycles → `rnd_data` stable, `slice_iR`=0. Then `rnd_ready`=1 → `rnd_valid`=0 next cycle, new round starts.
- VN, raw pairs 01,10,00,11 repeated → 2 accepted bits per 8 rounds, `rnd_data`=32'hAAAA_AAAA.
- Raw constant 1 for 64 rounds → `health_fail`=1 in that SAMPLE cycle, FSM in FAIL, `slice_iR`=0, no further words until reset.
- `reset` pulsed mid-RUN → `slice_iR`=0 immediately. After release, the first word needs a full `WORD_W` rounds.
